// File: rtl/psum_quant_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : psum_quant_ctrl_if
// Description : Stream bundle for psum_quant_ctrl. Carries the partial-product
//               input stream and the quantized result output stream.
//               master : producer of partial products / consumer of results
//               slave  : the psum_quant_ctrl block itself
// Ports       : in_valid/in_ready/in_data    partial-product handshake
//               out_valid/out_ready/out_data result handshake
// Revision    : 1.0  initial release
// ============================================================================
interface psum_quant_ctrl_if #(
  parameter int INTERNAL_BITS = 32,
  parameter int DATA_BITS     = 16
);
  logic                     in_valid;
  logic                     in_ready;
  logic [INTERNAL_BITS-1:0] in_data;
  logic                     out_valid;
  logic                     out_ready;
  logic [DATA_BITS-1:0]     out_data;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface
`default_nettype wire

// File: rtl/psum_quant_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : psum_quant_ctrl
// Description : Accumulate-then-truncate sequencer for the conv back end.
//               Per output: preload the bias, add cfg_len signed partial
//               products, optionally clamp negatives (ReLU), drop FRAC_BITS
//               fraction bits and emit DATA_BITS over valid/ready. Repeats
//               cfg_num_out times per job, then pulses done.
// Ports       : clk, rst            clock, synchronous active-high reset
//               start               one-cycle job start (honoured in IDLE)
//               cfg_len/num_out/bias/relu  job config, latched on start
//               bus (slave)         in_* partial products, out_* results
//               busy, done          status; done is a one-cycle pulse
// Options     : `define QUANT_SAT_EN to saturate the result to the signed
//               DATA_BITS range instead of wrapping on overflow.
// Revision    : 1.0  initial release
// ============================================================================
module psum_quant_ctrl #(
  parameter int INTERNAL_BITS = 32,
  parameter int DATA_BITS     = 16,
  parameter int FRAC_BITS     = 8,
  parameter int LEN_BITS      = 10,
  parameter int NUM_BITS      = 16
) (
  input  wire logic                     clk,
  input  wire logic                     rst,
  input  wire logic                     start,
  input  wire logic [LEN_BITS-1:0]      cfg_len,
  input  wire logic [NUM_BITS-1:0]      cfg_num_out,
  input  wire logic [INTERNAL_BITS-1:0] cfg_bias,
  input  wire logic                     cfg_relu,
  psum_quant_ctrl_if.slave              bus,
  output logic                          busy,
  output logic                          done
);

  localparam logic [1:0] c_st_idle = 2'd0;
  localparam logic [1:0] c_st_acc  = 2'd1;
  localparam logic [1:0] c_st_out  = 2'd2;
  localparam logic [1:0] c_st_fin  = 2'd3;

`ifdef QUANT_SAT_EN
  // Largest / smallest accumulator values representable at the output scale.
  localparam logic [INTERNAL_BITS-1:0] c_sat_hi =
    {{(INTERNAL_BITS-DATA_BITS-FRAC_BITS+1){1'b0}}, {(DATA_BITS-1){1'b1}}, {FRAC_BITS{1'b0}}};
  localparam logic [INTERNAL_BITS-1:0] c_sat_lo =
    {{(INTERNAL_BITS-DATA_BITS-FRAC_BITS+1){1'b1}}, {(DATA_BITS-1+FRAC_BITS){1'b0}}};
`endif

  logic [1:0]               r_state;
  logic [LEN_BITS-1:0]      r_len;
  logic [LEN_BITS-1:0]      r_term_cnt;
  logic [NUM_BITS-1:0]      r_num;
  logic [NUM_BITS-1:0]      r_out_cnt;
  logic [INTERNAL_BITS-1:0] r_bias;
  logic [INTERNAL_BITS-1:0] r_acc;
  logic                     r_relu;
  logic [DATA_BITS-1:0]     r_out_data;

  logic [INTERNAL_BITS-1:0] w_acc_sum;
  logic                     w_in_fire;
  logic                     w_out_fire;
  logic                     w_last_term;
  logic                     w_last_out;

  // ReLU, optional saturation, then drop the fraction bits.
  function automatic logic [DATA_BITS-1:0] quant(
    input logic [INTERNAL_BITS-1:0] a,
    input logic                     relu
  );
    logic [INTERNAL_BITS-1:0] r;
    r = (relu && a[INTERNAL_BITS-1]) ? '0 : a;
`ifdef QUANT_SAT_EN
    if ($signed(r) > $signed(c_sat_hi))
      return {1'b0, {(DATA_BITS-1){1'b1}}};
    else if ($signed(r) < $signed(c_sat_lo))
      return {1'b1, {(DATA_BITS-1){1'b0}}};
`endif
    return r[FRAC_BITS+DATA_BITS-1:FRAC_BITS];
  endfunction

  assign w_acc_sum   = r_acc + bus.in_data;
  assign w_in_fire   = bus.in_valid  && (r_state == c_st_acc);
  assign w_out_fire  = bus.out_ready && (r_state == c_st_out);
  // Widened by one bit so the +1 cannot wrap at the counter maximum.
  assign w_last_term = ({1'b0, r_term_cnt} + (LEN_BITS+1)'(1)) == {1'b0, r_len};
  assign w_last_out  = ({1'b0, r_out_cnt}  + (NUM_BITS+1)'(1)) == {1'b0, r_num};

  // Status/handshake outputs decode directly from the registered state.
  assign bus.in_ready  = (r_state == c_st_acc);
  assign bus.out_valid = (r_state == c_st_out);
  assign bus.out_data  = r_out_data;
  assign busy          = (r_state != c_st_idle);
  assign done          = (r_state == c_st_fin);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= c_st_idle;
      r_len      <= '0;
      r_term_cnt <= '0;
      r_num      <= '0;
      r_out_cnt  <= '0;
      r_bias     <= '0;
      r_acc      <= '0;
      r_relu     <= 1'b0;
      r_out_data <= '0;
    end else begin
      case (r_state)
        c_st_idle: begin
          if (start) begin
            r_len      <= cfg_len;
            r_num      <= cfg_num_out;
            r_bias     <= cfg_bias;
            r_relu     <= cfg_relu;
            r_acc      <= cfg_bias;
            r_term_cnt <= '0;
            r_out_cnt  <= '0;
            if (cfg_num_out == '0) begin
              r_state <= c_st_fin;
            end else if (cfg_len == '0) begin
              // Zero-term outputs are the bias alone.
              r_state    <= c_st_out;
              r_out_data <= quant(cfg_bias, cfg_relu);
            end else begin
              r_state <= c_st_acc;
            end
          end
        end

        c_st_acc: begin
          if (w_in_fire) begin
            r_acc      <= w_acc_sum;
            r_term_cnt <= r_term_cnt + LEN_BITS'(1);
            if (w_last_term) begin
              // Quantize the final sum now so out_data is ready with out_valid.
              r_state    <= c_st_out;
              r_out_data <= quant(w_acc_sum, r_relu);
            end
          end
        end

        c_st_out: begin
          if (w_out_fire) begin
            r_out_cnt <= r_out_cnt + NUM_BITS'(1);
            if (w_last_out) begin
              r_state <= c_st_fin;
            end else begin
              r_acc      <= r_bias;
              r_term_cnt <= '0;
              if (r_len == '0) begin
                r_out_data <= quant(r_bias, r_relu);
              end else begin
                r_state <= c_st_acc;
              end
            end
          end
        end

        c_st_fin: begin
          r_state <= c_st_idle;
        end

        default: begin
          r_state <= c_st_idle;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_psum_quant_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_psum_quant_ctrl
// Description : Self-checking bench for psum_quant_ctrl. Directed jobs from
//               the test plan plus randomized jobs, compared against an
//               integer-arithmetic reference model of the quantized sum.
// Revision    : 1.0  initial release
// ============================================================================
module tb_psum_quant_ctrl;

  localparam int IB = 32;
  localparam int DB = 16;
  localparam int FB = 8;

  logic          clk;
  logic          rst;
  logic          start;
  logic [9:0]    cfg_len;
  logic [15:0]   cfg_num_out;
  logic [IB-1:0] cfg_bias;
  logic          cfg_relu;
  logic          busy;
  logic          done;

  int n_checks;
  int n_err;

  logic [31:0] dterms[$];

  psum_quant_ctrl_if #(.INTERNAL_BITS(IB), .DATA_BITS(DB)) bus ();

  psum_quant_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .cfg_len     (cfg_len),
    .cfg_num_out (cfg_num_out),
    .cfg_bias    (cfg_bias),
    .cfg_relu    (cfg_relu),
    .bus         (bus.slave),
    .busy        (busy),
    .done        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Reference: exact signed value of the wrapped sum, ReLU, optional clamp,
  // then floor-divide by 2^FB and keep the low DB bits.
  function automatic logic [15:0] model_quant(input logic [31:0] sum, input bit relu);
    longint s;
    longint q;
    s = longint'($signed(sum));
    if (relu && s < 0) s = 0;
`ifdef QUANT_SAT_EN
    if (s > longint'(32767) * 256) return 16'h7FFF;
    if (s < longint'(-32768) * 256) return 16'h8000;
`endif
    q = s >>> FB;
    return 16'(q & 64'hFFFF);
  endfunction

  function automatic logic [31:0] rand_term();
    case ($urandom_range(0, 3))
      0: return 32'($urandom_range(0, 131072)) - 32'd65536;
      1: return 32'($urandom_range(0, 8388608)) - 32'd4194304;
      2: return $urandom;
      default: return 32'd0;
    endcase
  endfunction

  task automatic run_job(input logic [31:0] bias, input int len, input int num,
                         input bit relu, input int bp, input bit gaps);
    logic [31:0] acc_m;
    logic [15:0] exp;
    logic [31:0] term;
    int got;
    int budget;
    int hold;
    start       = 1'b1;
    cfg_bias    = bias;
    cfg_len     = 10'(len);
    cfg_num_out = 16'(num);
    cfg_relu    = relu;
    @(negedge clk);
    // Scramble config after start: the DUT must use its latched copy.
    start       = 1'b0;
    cfg_bias    = $urandom;
    cfg_len     = 10'($urandom);
    cfg_num_out = 16'($urandom);
    cfg_relu    = 1'($urandom);
    chk_eq("busy_after_start", 32'(busy), 32'd1);
    if (num == 0) begin
      chk_eq("done_empty_job", 32'(done), 32'd1);
      chk_eq("no_valid_empty_job", 32'(bus.out_valid), 32'd0);
      @(negedge clk);
      chk_eq("done_cleared_empty", 32'(done), 32'd0);
      chk_eq("idle_after_empty", 32'(busy), 32'd0);
      return;
    end
    for (int o = 0; o < num; o++) begin
      acc_m  = bias;
      got    = 0;
      budget = 0;
      while (got < len && budget < 200) begin
        chk_eq("no_early_valid", 32'(bus.out_valid), 32'd0);
        bus.in_valid = !(gaps && $urandom_range(0, 2) == 0);
        bus.in_data  = $urandom;
        if (bus.in_valid && bus.in_ready) begin
          term = (dterms.size() > 0) ? dterms.pop_front() : rand_term();
          bus.in_data = term;
          acc_m = acc_m + term;
          got++;
        end
        @(negedge clk);
        budget++;
      end
      if (budget >= 200) chk_eq("acc_timeout", 32'd0, 32'd1);
      bus.in_valid = 1'b0;
      exp = model_quant(acc_m, relu);
      chk_eq("out_valid_latency", 32'(bus.out_valid), 32'd1);
      chk_eq("out_data", 32'(bus.out_data), 32'(exp));
      hold = (o == 0) ? bp : $urandom_range(0, 2);
      for (int k = 0; k < hold; k++) begin
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'($urandom);
        bus.in_data   = $urandom;
        @(negedge clk);
        chk_eq("hold_valid", 32'(bus.out_valid), 32'd1);
        chk_eq("hold_data", 32'(bus.out_data), 32'(exp));
        chk_eq("hold_in_ready", 32'(bus.in_ready), 32'd0);
        chk_eq("hold_no_done", 32'(done), 32'd0);
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;
      if (o < num - 1) chk_eq("no_done_mid_job", 32'(done), 32'd0);
    end
    chk_eq("done_pulse", 32'(done), 32'd1);
    @(negedge clk);
    chk_eq("done_one_cycle", 32'(done), 32'd0);
    chk_eq("idle_after_job", 32'(busy), 32'd0);
    chk_eq("no_valid_after_job", 32'(bus.out_valid), 32'd0);
  endtask

  initial begin
    n_checks      = 0;
    n_err         = 0;
    rst           = 1'b1;
    start         = 1'b0;
    cfg_len       = '0;
    cfg_num_out   = '0;
    cfg_bias      = '0;
    cfg_relu      = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk_eq("rst_in_ready", 32'(bus.in_ready), 32'd0);
    chk_eq("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk_eq("rst_busy", 32'(busy), 32'd0);
    chk_eq("rst_done", 32'(done), 32'd0);
    chk_eq("rst_out_data", 32'(bus.out_data), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Basic three-term job.
    dterms = '{32'h100, 32'h200, 32'h300};
    run_job(32'h0, 3, 1, 1'b0, 0, 1'b0);
    // Bias with a dropped fraction.
    dterms = '{32'h56};
    run_job(32'h0012_3400, 1, 1, 1'b0, 0, 1'b0);
    // Negative sum with and without ReLU.
    dterms = '{32'hFFFF_FF00};
    run_job(32'h0, 1, 1, 1'b0, 0, 1'b0);
    dterms = '{32'hFFFF_FF00};
    run_job(32'h0, 1, 1, 1'b1, 0, 1'b0);
    // Overflow in both directions.
    dterms = '{32'h0100_0000};
    run_job(32'h0, 1, 1, 1'b0, 0, 1'b0);
    dterms = '{32'hFE00_0000};
    run_job(32'h0, 1, 1, 1'b0, 0, 1'b0);
    // Two outputs with five cycles of backpressure on the first.
    run_job(32'h0000_0A00, 2, 2, 1'b0, 5, 1'b1);
    // Empty job and bias-only outputs.
    run_job(32'h0, 3, 0, 1'b0, 0, 1'b0);
    run_job(32'h0000_1280, 0, 2, 1'b0, 2, 1'b0);

    // Reset in the middle of accumulation, then a fresh job.
    start = 1'b1; cfg_bias = 32'h1000; cfg_len = 10'd3; cfg_num_out = 16'd1; cfg_relu = 1'b0;
    @(negedge clk);
    start = 1'b0;
    bus.in_valid = 1'b1; bus.in_data = 32'h5000;
    @(negedge clk);
    bus.in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_eq("midrst_busy", 32'(busy), 32'd0);
    chk_eq("midrst_in_ready", 32'(bus.in_ready), 32'd0);
    chk_eq("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    chk_eq("midrst_done", 32'(done), 32'd0);
    chk_eq("midrst_out_data", 32'(bus.out_data), 32'd0);
    dterms = '{32'h100, 32'h300};
    run_job(32'h200, 2, 1, 1'b0, 0, 1'b0);

    // Randomized jobs.
    for (int j = 0; j < 25; j++) begin
      dterms.delete();
      run_job(rand_term(), $urandom_range(0, 5), $urandom_range(0, 3),
              1'($urandom), $urandom_range(0, 3), 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/psum_quant_ctrl.md
Name: psum_quant_ctrl

Overview:
- Sequencer for the accumulate-then-truncate back end of the conv datapath.
- Consumes a stream of signed INTERNAL_BITS partial products and sums a configured number of terms onto a bias. Applies optional ReLU, then reduces the sum to DATA_BITS by fixed-point truncation.
- Emits one DATA_BITS result per output pixel over a valid/ready handshake. Repeats for a configured number of outputs per job.
- Sits between the PE array's partial-product output and the output buffer writer.

Parameters:
- INTERNAL_BITS, 32, accumulator and input term width (signed two's complement).
- DATA_BITS, 16, output data width.
- FRAC_BITS, 8, fractional bits dropped. out_data = acc[FRAC_BITS+DATA_BITS-1:FRAC_BITS].
- LEN_BITS, 10, width of cfg_len.
- NUM_BITS, 16, width of cfg_num_out.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle job start; sampled only in IDLE.
- cfg_len  in  LEN_BITS  terms per output; latched on start.
- cfg_num_out  in  NUM_BITS  outputs per job; latched on start.
- cfg_bias  in  INTERNAL_BITS  accumulator preload for every output; latched on start.
- cfg_relu  in  1  clamp negative sums to 0 before truncation; latched on start.
- in_valid  in  1  partial-product valid.
- in_ready  out  1  high only in ACC.
- in_data  in  INTERNAL_BITS  signed partial product.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accept.
- out_data  out  DATA_BITS  truncated result.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at job end.

Behaviour:
- Reset: state=IDLE. in_ready, out_valid, busy, done = 0. out_data=0. Accumulator and counters = 0.
- States: IDLE, ACC, OUT, FIN.
- IDLE + start:
  - Latch all cfg_* inputs; acc <= cfg_bias; term_cnt <= 0; out_cnt <= 0.
  - cfg_num_out==0 -> FIN.
  - cfg_len==0 -> OUT.
  - Otherwise -> ACC.
- ACC:
  - in_ready=1. Each cycle with in_valid&in_ready: acc <= acc + in_data (modulo 2^INTERNAL_BITS wrap), term_cnt++.
  - When the accepted term is number cfg_len, go to OUT on the next edge.
  - Result registered: out_valid rises the cycle after the last term is accepted (latency 1).
- OUT:
  - out_valid=1. out_data held stable until the handshake.
  - Computation: r = (cfg_relu && acc[MSB]) ? 0 : acc; out_data = r[FRAC_BITS+DATA_BITS-1:FRAC_BITS]. Upper bits are discarded unless the optional feature is enabled.
  - On out_valid&out_ready: out_cnt++. If out_cnt+1==cfg_num_out -> FIN. Else acc <= cfg_bias, term_cnt <= 0, then -> ACC (or stay in OUT with the bias result if cfg_len==0).
  - out_ready low: hold state and data indefinitely; no terms are accepted.
- FIN: done=1 for exactly one cycle, then -> IDLE.
- start while busy: ignored. Latched config does not change mid-job.
- rst mid-job: the synchronous reset wins over every transition. On the next edge all outputs return to reset values and any partial sum is lost.
- in_valid while not in ACC: ignored; in_ready=0.

Optional Feature:
- Macro: QUANT_SAT_EN.
- Defined: before slicing, r is saturated to the signed DATA_BITS range at the output scale.
  - If r > (2^(DATA_BITS-1)-1)<<FRAC_BITS (bit-exact comparison on the full word), out_data = 0x7FFF.
  - If r < -(2^(DATA_BITS-1))<<FRAC_BITS, out_data = 0x8000.
  - Otherwise, plain truncation.
- Undefined: plain bit-slice truncation; overflow wraps.

Test Plan:
- Basic job: bias=0, len=3, num_out=1, terms 0x100, 0x200, 0x300 -> one output 0x0006, out_valid 1 cycle after 3rd accept, done pulse after handshake.
- Truncation/bias: bias=0x00123400, len=1, term 0x56 -> out_data 0x1234. Fraction 0x56 dropped.
- Negative/ReLU: len=1, term 0xFFFFFF00 -> 0xFFFF with relu=0; 0x0000 with relu=1.
- Overflow: len=1, term 0x01000000 -> 0x0000 without QUANT_SAT_EN, 0x7FFF with it. Term 0xFE000000 -> 0x0000 / 0x8000 respectively.
- Backpressure and multi-output: num_out=2, len=2, out_ready low 5 cycles -> out_data stable, in_ready=0 throughout; second output uses a fresh bias; done only after the 2nd handshake. num_out=0 -> done 1 cycle after start, no out_valid.
- Reset mid-ACC after 1 of 3 terms, then new job -> outputs idle after reset; new job result contains no stale partial sum.
